// File: rtl/led_s2p_rx.sv
// led_s2p_rx: LED shift-chain serial-to-parallel receiver; clk, rst (async, active-high), s_clk/s_data/s_clrn/s_pen link in, data_out/data_valid/frame_err/busy/timeout out; optional idle abort via LED_S2P_TIMEOUT_EN
module led_s2p_rx #(
  parameter int DATA_BITS = 16,
  parameter logic [DATA_BITS-1:0] RESET_VALUE = '0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_clk,
  input  logic                 s_data,
  input  logic                 s_clrn,
  input  logic                 s_pen,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 timeout
);
  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] FULL_C = CW'(DATA_BITS);
  localparam logic [CW-1:0] MAX_C = CW'(DATA_BITS + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;
  logic [1:0] ck_s, dt_s, cl_s, pe_s;
  logic ck_d, pe_d;
  logic shift_ev, latch_ev, clr, s_bit, good, to_hit;
  logic [CW-1:0] cnt, sh_cnt, cnt_n;
  logic [DATA_BITS-1:0] sr, sh_sr, sr_n, dout_n;
  logic valid_n, ferr_n;
  state_t state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ck_s <= '0;
      dt_s <= '0;
      cl_s <= 2'b11;
      pe_s <= '0;
      ck_d <= 1'b0;
      pe_d <= 1'b0;
    end else begin
      ck_s <= {ck_s[0], s_clk};
      dt_s <= {dt_s[0], s_data};
      cl_s <= {cl_s[0], s_clrn};
      pe_s <= {pe_s[0], s_pen};
      ck_d <= ck_s[1];
      pe_d <= pe_s[1];
    end
  assign shift_ev = ck_s[1] & ~ck_d;
  assign latch_ev = pe_s[1] & ~pe_d;
  assign clr = ~cl_s[1];
  assign s_bit = dt_s[1];
`ifdef LED_S2P_TIMEOUT_EN
  localparam logic [15:0] TO_C = 16'(TIMEOUT_CYCLES);
  logic [15:0] idle, idle_n;
  logic to_q;
  assign to_hit = !clr && !shift_ev && !latch_ev && cnt != '0 && idle == TO_C;
  assign idle_n = (clr || shift_ev || latch_ev || to_hit || cnt == '0) ? '0 : idle + 16'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idle <= '0;
      to_q <= 1'b0;
    end else begin
      idle <= idle_n;
      to_q <= to_hit;
    end
  assign timeout = to_q;
`else
  assign to_hit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      sr <= '0;
      data_out <= RESET_VALUE;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      sr <= sr_n;
      data_out <= dout_n;
      data_valid <= valid_n;
      frame_err <= ferr_n;
    end
  // shift is applied before the latch looks at cnt and sr in the same cycle
  always_comb begin
    sh_cnt = (shift_ev && cnt != MAX_C) ? cnt + 1'b1 : cnt;
    sh_sr = shift_ev ? {sr[DATA_BITS-2:0], s_bit} : sr;
    good = latch_ev && sh_cnt == FULL_C;
    sr_n = clr ? '0 : sh_sr;
    cnt_n = (clr || latch_ev || to_hit) ? '0 : sh_cnt;
    dout_n = (!clr && good) ? sh_sr : data_out;
    valid_n = !clr && good;
    ferr_n = (clr || !latch_ev) ? frame_err : !good;
  end
  always_comb begin
    state = cnt == '0 ? IDLE : cnt < FULL_C ? SHIFT : cnt == FULL_C ? FULL : OVER;
    busy = state != IDLE;
  end
endmodule
